// File: rtl/sigma_delta_popcount.sv
// Combinational adder-tree popcount of a parallel sigma-delta word.
// Reusable by any block that turns an OUTLEN-bit word into a ones count.
module sigma_delta_popcount #(
  parameter int unsigned OUTLEN = 16,
  localparam int unsigned WIDTH = $clog2(OUTLEN)
) (
  input  logic [OUTLEN-1:0] in,
  output logic [WIDTH:0]    count
);

  localparam int unsigned CW = WIDTH + 1;

  logic [CW-1:0] acc [OUTLEN];

  // In-place pairwise reduction: each level halves the number of partial sums.
  always_comb begin
    for (int i = 0; i < OUTLEN; i++) begin
      acc[i] = CW'(in[i]);
    end
    for (int n = OUTLEN / 2; n >= 1; n = n / 2) begin
      for (int i = 0; i < n; i++) begin
        acc[i] = acc[2*i] + acc[2*i+1];
      end
    end
    count = acc[0];
  end

endmodule

// File: rtl/sigma_delta_fast_decimator.sv
// Sinc^3 CIC decimator for a parallel sigma-delta stream: each en word becomes a
// bipolar count, DEC words are integrated and combed into one signed sample.
module sigma_delta_fast_decimator #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned OUTLEN    = 16,
  parameter int unsigned DEC       = 8,
  localparam int unsigned LOG2_DEC  = $clog2(DEC),
  localparam int unsigned OUT_WIDTH = WIDTH + 2 + 3 * LOG2_DEC
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [OUTLEN-1:0]           in,
  output logic signed [OUT_WIDTH-1:0] out,
  output logic                        outValid
);

  localparam logic [LOG2_DEC-1:0] LastCnt = LOG2_DEC'(DEC - 1);

  logic [WIDTH:0]           p;
  logic [OUT_WIDTH-1:0]     x;
  logic [OUT_WIDTH-1:0]     s_q, i1_q, i2_q, i3_q;
  logic [OUT_WIDTH-1:0]     d1_q, d2_q, d3_q, out_q;
  logic [OUT_WIDTH-1:0]     c1, c2, c3;
  logic [LOG2_DEC-1:0]      dec_cnt_q;
  logic                     comb_go_q, out_valid_q;

  sigma_delta_popcount #(
    .OUTLEN(OUTLEN)
  ) u_popcount (
    .in   (in),
    .count(p)
  );

  // Modulo 2^OUT_WIDTH arithmetic throughout; wrap is what keeps the CIC exact.
  always_comb begin
    x  = (OUT_WIDTH'(p) << 1) - OUT_WIDTH'(OUTLEN);
    c1 = i3_q - d1_q;
    c2 = c1 - d2_q;
    c3 = c2 - d3_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q         <= '0;
      i1_q        <= '0;
      i2_q        <= '0;
      i3_q        <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      d3_q        <= '0;
      out_q       <= '0;
      dec_cnt_q   <= '0;
      comb_go_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      comb_go_q   <= en && (dec_cnt_q == LastCnt);
      out_valid_q <= comb_go_q;
      if (en) begin
        s_q       <= x;
        i1_q      <= i1_q + s_q;
        i2_q      <= i2_q + i1_q;
        i3_q      <= i3_q + i2_q;
        dec_cnt_q <= dec_cnt_q + 1'b1;
      end
      // Comb samples the pre-edge i3, so a coincident en loses nothing.
      if (comb_go_q) begin
        d1_q  <= i3_q;
        d2_q  <= c1;
        d3_q  <= c2;
        out_q <= c3;
      end
    end
  end

  assign out      = out_q;
  assign outValid = out_valid_q;

endmodule

// File: tb/tb_sigma_delta_fast_decimator.sv
// Directed bench for the sinc^3 decimator: a word-level CIC model pushes the expected
// sample and its arrival cycle; a negedge monitor pops and compares on each outValid.
module tb_sigma_delta_fast_decimator;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [15:0]        din;
  logic signed [14:0] dout;
  logic               dvalid;

  sigma_delta_fast_decimator #(
    .WIDTH (4),
    .OUTLEN(16),
    .DEC   (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .in      (din),
    .out     (dout),
    .outValid(dvalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [14:0] val;
    int                 at;
  } exp_t;

  exp_t               q[$];
  int                 checks = 0;
  int                 failures = 0;
  logic signed [14:0] m_s, m_i1, m_i2, m_i3, m_d1, m_d2, m_d3;
  int                 m_cnt;
  logic signed [14:0] last_out = '0;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    {m_s, m_i1, m_i2, m_i3, m_d1, m_d2, m_d3} = '0;
    m_cnt = 0;
    q.delete();
  endtask

  // Word-level CIC: integrators use old values, comb runs on the updated i3.
  task automatic model_word(input logic [15:0] w);
    logic signed [14:0] c1, c2, c3;
    m_i3 = m_i3 + m_i2;
    m_i2 = m_i2 + m_i1;
    m_i1 = m_i1 + m_s;
    m_s  = 15'(2 * $countones(w) - 16);
    if (m_cnt == 7) begin
      c1 = m_i3 - m_d1;
      c2 = c1 - m_d2;
      c3 = c2 - m_d3;
      m_d1 = m_i3;
      m_d2 = c1;
      m_d3 = c2;
      q.push_back('{val: c3, at: cyc + 2});
    end
    m_cnt = (m_cnt + 1) % 8;
  endtask

  // Called #1 after a posedge; en is seen on the next edge.
  task automatic word(input logic [15:0] w, input int gap);
    en  = 1'b1;
    din = w;
    model_word(w);
    @(posedge clk); #1;
    en = 1'b0;
    repeat (gap - 1) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [15:0] rand_word(input int p);
    logic [15:0] w = '0;
    while ($countones(w) < p) w[$urandom_range(15, 0)] = 1'b1;
    return w;
  endfunction

  task automatic run_const(input logic [15:0] w, input int n, input int gap,
                           input int steady, input string tag);
    for (int k = 0; k < n; k++) word(w, gap);
    repeat (3) @(posedge clk);
    #1;
    chk(tag, last_out, steady);
  endtask

  task automatic run_level(input int lvl, input int n, input string tag);
    for (int k = 0; k < n; k++) word(rand_word(8 + lvl), 1);
    repeat (3) @(posedge clk);
    #1;
    chk(tag, last_out, lvl * 1024);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (dvalid === 1'b1) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("out_value", dout, e.val);
          chk("valid_cycle", cyc, e.at);
        end
        last_out = dout;
      end else if (rst === 1'b0) begin
        chk("out_hold", dout, last_out);
      end
    end
  end

  initial begin
    int levels[5] = '{7, -8, 4, -4, 0};
    rst = 1'b1;
    en  = 1'b0;
    din = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", dout, 0);
    chk("reset_valid", dvalid, 0);
    rst = 1'b0;

    run_const(16'hAAAA, 16, 16, 0, "aaaa_zero");
    run_const(16'hFFFF, 48, 3, 8192, "ffff_pos_full");
    run_const(16'h0000, 48, 2, -8192, "zero_neg_full");
    run_const(16'h0FFF, 48, 2, 4096, "p12_steady");
    run_const(16'h00FF, 48, 1, 0, "p8_steady");
    run_const(16'hFFFF, 48, 1, 8192, "max_rate_steady");

    // Async reset while a valid pulse is on the output.
    for (int k = 0; k < 8; k++) word(16'hFFFF, 1);
    @(posedge clk); #1;
    chk("valid_before_rst", dvalid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out", dout, 0);
    chk("async_rst_valid", dvalid, 0);
    model_reset();
    last_out = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_const(16'hFFFF, 48, 2, 8192, "post_rst_steady");

    foreach (levels[i]) run_level(levels[i], 48, "dc_level_steady");
    for (int k = 0; k < 80; k++) word(rand_word(8 + levels[k % 5]), 1);
    run_level(7, 48, "post_chirp_steady");

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
